// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among four byte
// requesters, with per-requester grant lock and a completion watchdog.
module uart_tx_arbiter #(
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_lock,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [3:0]  grant,
    output logic        sent,
    output logic        timeout_err,
    input  logic        err_clr
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_ptr;
    logic [1:0]      r_own;
    logic [7:0]      r_data;
    logic [3:0]      r_grant;
    logic            r_sent;
    logic            r_err;
    logic [TW-1:0]   r_tcnt;
    logic [GW-1:0]   r_gcnt;

    logic [1:0]      w_pick;
    logic [1:0]      w_idx;
    logic            w_wait;
    logic            w_tout;
    logic            w_gap_end;
    logic            w_cont;
    logic            w_acc;

    // Lowest rotation offset from r_ptr wins, so scan offsets downward.
    always_comb begin
        w_pick = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req_valid[r_ptr + 2'(i)]) begin
                w_pick = r_ptr + 2'(i);
            end
        end
    end

    assign w_wait    = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    // Counter is 0 in the first wait cycle, so T-2 flags the error at tx_en+T.
    assign w_tout    = w_wait && !tx_done && (r_tcnt == TW'(TIMEOUT - 2));
    assign w_gap_end = (r_state == S_GAP) && (r_gcnt == GW'(GAP_CYCLES));
    assign w_cont    = w_gap_end && req_lock[r_own] && req_valid[r_own];
    assign w_acc     = ((r_state == S_IDLE) && (|req_valid)) || w_cont;
    assign w_idx     = w_cont ? r_own : w_pick;

    assign req_ready   = (w_acc && !rst) ? (4'b0001 << w_idx) : 4'b0000;
    assign tx_en       = (r_state == S_LAUNCH);
    assign tx_data     = r_data;
    assign grant       = r_grant;
    assign sent        = r_sent;
    assign timeout_err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (|req_valid) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_done || w_tout) w_next = S_GAP;
                else if (tx_busy)      w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (tx_done || w_tout) w_next = S_GAP;
            end
            S_GAP: begin
                if (w_gap_end) w_next = w_cont ? S_LAUNCH : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 2'd0;
            r_own   <= 2'd0;
            r_data  <= 8'h00;
            r_grant <= 4'b0000;
            r_sent  <= 1'b0;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
            r_gcnt  <= '0;
        end else begin
            r_sent <= w_wait && tx_done;

            if (w_tout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (r_state == S_LAUNCH) begin
                r_tcnt <= '0;
            end else if (w_wait) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if ((r_state == S_GAP) && !w_gap_end) begin
                r_gcnt <= r_gcnt + 1'b1;
            end else begin
                r_gcnt <= '0;
            end

            if (w_acc) begin
                r_data  <= req_data[{w_idx, 3'b000} +: 8];
                r_own   <= w_idx;
                r_grant <= 4'b0001 << w_idx;
            end else if (w_gap_end) begin
                r_ptr   <= r_own + 2'd1;
                r_grant <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter
// against a transaction-level model of arbitration, watchdog and gaps.
module tb_uart_tx_arbiter;
    localparam int G = 16;
    localparam int T = 50;
    localparam int F = 10;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_lock = '0;
    logic        err_clr = 1'b0;

    logic [3:0]  rdy, gnt, rdy0, gnt0;
    logic [7:0]  txd, txd0;
    logic        txen, snt, err, txen0, snt0, err0;
    logic        busy, busy0;
    logic        done = 1'b0;
    logic        done0 = 1'b0;
    int          ucnt = 0;
    int          ucnt0 = 0;
    logic        uart_dead = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.GAP_CYCLES(G), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
        .req_ready(rdy), .tx_data(txd), .tx_en(txen),
        .tx_busy(busy), .tx_done(done),
        .grant(gnt), .sent(snt), .timeout_err(err), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.GAP_CYCLES(0), .TIMEOUT(T)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
        .req_ready(rdy0), .tx_data(txd0), .tx_en(txen0),
        .tx_busy(busy0), .tx_done(done0),
        .grant(gnt0), .sent(snt0), .timeout_err(err0), .err_clr(err_clr)
    );

    // Serializer stand-ins: busy for F clocks after tx_en, then a done pulse.
    always @(posedge clk) begin
        if (rst) begin
            ucnt <= 0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (txen && !uart_dead) begin
                ucnt <= F;
            end else if (ucnt != 0) begin
                ucnt <= ucnt - 1;
                if (ucnt == 1) done <= 1'b1;
            end
        end
    end
    assign busy = (ucnt != 0);

    always @(posedge clk) begin
        if (rst) begin
            ucnt0 <= 0;
            done0 <= 1'b0;
        end else begin
            done0 <= 1'b0;
            if (txen0) begin
                ucnt0 <= F;
            end else if (ucnt0 != 0) begin
                ucnt0 <= ucnt0 - 1;
                if (ucnt0 == 1) done0 <= 1'b1;
            end
        end
    end
    assign busy0 = (ucnt0 != 0);

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    ent_t q[4][$];
    int   start[4] = '{0, 0, 0, 0};
    logic [3:0] pop = '0;
    bit   hold = 0;
    int   order[$];
    int   dead_cnt = 0;
    bit   rand_phase = 0;
    bit   gap_phase = 0;
    bit   prev_rst = 0;
    int   n_sent = 0;
    int   d_main = -1;
    int   d_0 = -1;
    int   n_rdy0 = 0, n_txen0 = 0, n_done0 = 0, n_snt0 = 0;

    // Transaction-level model state.
    bit         m_busy = 0;
    int         m_own = 0;
    int         m_ptr = 0;
    int         m_L = -1;
    int         m_E = -1;
    int         m_S = -1;
    bit         m_err = 0;
    logic [7:0] m_byte = 8'h00;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive();
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (pop[k] && !hold && q[k].size() > 0) void'(q[k].pop_front());
            v[k] = (q[k].size() > 0) && (cyc >= start[k]);
            req_data[8*k +: 8] = v[k] ? q[k][0].d : 8'h00;
            req_lock[k] = v[k] ? q[k][0].l : 1'b0;
        end
        pop = '0;
        req_valid = v;
    endtask

    task automatic check_cycle();
        logic [3:0] er;
        int k;
        if (prev_rst) chk("rst_txdata", txd, 8'h00);
        prev_rst = rst;
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_err = 0;
            m_L = -1; m_E = -1; m_S = -1;
            pop = '0;
            return;
        end
        er = '0;
        if (!m_busy) begin
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (req_valid[k] && er == 0) er = 4'b0001 << k;
            end
        end else if (cyc == m_E && req_lock[m_own] && req_valid[m_own]) begin
            er = 4'b0001 << m_own;
        end
        chk("ready", rdy, er);
        chk("tx_en", txen, cyc == m_L);
        if (cyc == m_L) chk("tx_data", txd, m_byte);
        chk("grant", gnt, m_busy ? (4'b0001 << m_own) : 4'b0000);
        chk("sent", snt, cyc == m_S);
        chk("timeout_err", err, m_err);

        pop = rdy;
        if (rdy != 0) order.push_back(oh2i(rdy));
        if (snt) n_sent++;
        if (txen) begin
            if (dead_cnt > 0) begin
                uart_dead = 1'b1;
                dead_cnt--;
            end else begin
                uart_dead = rand_phase && ($urandom_range(0, 5) == 0);
            end
        end

        if (gap_phase) begin
            if (txen && d_main >= 0) chk("gap16_spacing", cyc - d_main, 18);
            if (txen0 && d_0 >= 0) chk("gap0_spacing", cyc - d_0, 2);
            if (txen0) begin
                chk("gap0_grant", gnt0, 4'b0001);
                chk("gap0_data", txd0, 8'h5A);
            end
            if (txen) d_main = -1;
            if (txen0) d_0 = -1;
            if (done) d_main = cyc;
            if (done0) d_0 = cyc;
            if (rdy0 != 0) n_rdy0++;
            if (txen0) n_txen0++;
            if (done0) n_done0++;
            if (snt0) n_snt0++;
        end

        if (m_busy && m_E < 0 && cyc > m_L) begin
            if (done) begin
                m_E = cyc + 1 + G;
                m_S = cyc + 1;
            end else if (cyc - m_L == T - 1) begin
                m_E = cyc + 1 + G;
                m_err = 1;
            end else if (err_clr) begin
                m_err = 0;
            end
        end else if (err_clr) begin
            m_err = 0;
        end

        if (er != 0) begin
            k = oh2i(er);
            m_own = k;
            m_busy = 1;
            m_L = cyc + 1;
            m_E = -1;
            m_byte = req_data[8*k +: 8];
        end else if (m_busy && cyc == m_E) begin
            m_busy = 0;
            m_ptr = (m_own + 1) % 4;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic push(int k, logic [7:0] d, logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        q[k].push_back(e);
    endtask

    function automatic bit pending();
        return m_busy || q[0].size() > 0 || q[1].size() > 0 ||
               q[2].size() > 0 || q[3].size() > 0;
    endfunction

    task automatic drain(string tag, int maxc, bit rnd);
        int n;
        n = 0;
        while (pending() && n < maxc) begin
            err_clr = rnd && ($urandom_range(0, 15) == 0);
            step();
            n++;
        end
        err_clr = 1'b0;
        chk(tag, n < maxc, 1'b1);
    endtask

    task automatic chk_order(string tag, int exp[$]);
        chk({tag, "_len"}, order.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(tag, (i < order.size()) ? order[i] : -1, exp[i]);
        end
    endtask

    initial begin
        int nb, nm;
        drive();
        step();
        rst = 1'b0;
        step();

        // Single byte from requester 2.
        order.delete();
        n_sent = 0;
        push(2, 8'hA5, 1'b0);
        drive();
        drain("single_drain", 200, 0);
        chk_order("single_order", '{2});
        chk("single_sent", n_sent, 1);

        // Round-robin with all four valid: fresh reset so ptr starts at 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        order.delete();
        push(0, 8'h11, 1'b0);
        push(0, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(2, 8'h33, 1'b0);
        push(3, 8'h44, 1'b0);
        drive();
        drain("rr_drain", 400, 0);
        chk_order("rr_order", '{0, 1, 2, 3, 0});

        // Lock: requester 1 holds the grant across its three bytes.
        order.delete();
        push(0, 8'hA0, 1'b0);
        push(1, 8'h01, 1'b0);
        push(1, 8'h02, 1'b1);
        push(1, 8'h03, 1'b1);
        push(3, 8'hB3, 1'b0);
        drive();
        drain("lock_drain", 400, 0);
        chk_order("lock_order", '{1, 1, 1, 3, 0});

        // Timeout: first launch goes to a dead serializer.
        order.delete();
        n_sent = 0;
        dead_cnt = 1;
        push(2, 8'h55, 1'b0);
        push(3, 8'h66, 1'b0);
        drive();
        drain("tout_drain", 400, 0);
        chk_order("tout_order", '{2, 3});
        chk("tout_sent", n_sent, 1);
        chk("tout_err_set", err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        chk("tout_err_clr", err, 1'b0);

        // Reset in the middle of a byte.
        push(1, 8'h77, 1'b0);
        drive();
        nb = 0;
        while (!busy && nb < 100) begin
            step();
            nb++;
        end
        chk("mid_reach_busy", busy, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        order.delete();
        push(3, 8'h93, 1'b0);
        push(0, 8'h90, 1'b0);
        drive();
        drain("mid_drain", 300, 0);
        chk_order("mid_order", '{0, 3});

        // Randomized traffic with dead launches and random error clears.
        rand_phase = 1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                start[k] = cyc + int'($urandom_range(0, 60));
                nm = int'($urandom_range(0, 2));
                for (int m = 0; m < nm; m++) begin
                    nb = int'($urandom_range(1, 3));
                    for (int b = 0; b < nb; b++) begin
                        push(k, 8'($urandom), b != 0);
                    end
                end
            end
            drive();
            drain("rand_drain", 3000, 1);
        end
        rand_phase = 0;
        uart_dead = 1'b0;
        for (int k = 0; k < 4; k++) start[k] = 0;

        // Gap spacing on both instances with a locked streaming requester.
        rst = 1'b1;
        step();
        rst = 1'b0;
        gap_phase = 1;
        hold = 1;
        push(0, 8'h5A, 1'b1);
        drive();
        repeat (150) step();
        hold = 0;
        q[0].delete();
        drive();
        drain("gap_drain", 300, 0);
        repeat (4) step();
        gap_phase = 0;
        chk("gap0_ready_vs_txen", n_rdy0, n_txen0);
        chk("gap0_done_vs_sent", n_done0, n_snt0);
        chk("gap0_err", err0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
